// File: rtl/weight_fetch_ctrl_if.sv
// Bundle between the weight fetch controller, the dual-port weightROM and the PE.
// master is the controller side; slave is the ROM/PE side.
interface weight_fetch_ctrl_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0]   addr_weight_1;
    logic [ADDR_W-1:0]   addr_weight_2;
    logic [DATA_W-1:0]   dout_weight_1;
    logic [DATA_W-1:0]   dout_weight_2;
    logic                w_valid;
    logic                w_ready;
    logic [2*DATA_W-1:0] w_data;
    logic                w_last;

    modport master (
        output addr_weight_1, addr_weight_2, w_valid, w_data, w_last,
        input  dout_weight_1, dout_weight_2, w_ready
    );

    modport slave (
        input  addr_weight_1, addr_weight_2, w_valid, w_data, w_last,
        output dout_weight_1, dout_weight_2, w_ready
    );
endinterface

// File: rtl/weight_fetch_ctrl.sv
// Burst address generator and packer: streams weight pairs from the dual-port weightROM
// to the PE, with credit-based issue so the output FIFO can absorb PE backpressure.
module weight_fetch_ctrl #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int ROM_LAT    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_pairs,
    output logic              busy,
    output logic              done,
    weight_fetch_ctrl_if.master bus
);
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int CRED_W  = $clog2(FIFO_DEPTH + ROM_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   next_addr;
    logic [CNT_W-1:0]    pairs_left;
    logic [ROM_LAT-1:0]  tag_valid;
    logic [ROM_LAT-1:0]  tag_last;
    logic [2*DATA_W:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [FCNT_W-1:0]   fifo_count;
    logic [CRED_W-1:0]   inflight;
    logic                issue;
    logic                push;
    logic                pop;
    logic                burst_end;

    // Credits count every pair already issued but not yet popped; a same-cycle pop is not credited.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LAT; i++) begin
            inflight = inflight + CRED_W'(tag_valid[i]);
        end
        issue = (state == ISSUE) &&
                ((inflight + CRED_W'(fifo_count)) < CRED_W'(FIFO_DEPTH));
    end

    assign push      = tag_valid[ROM_LAT-1];
    assign pop       = bus.w_valid && bus.w_ready;
    assign burst_end = pop && bus.w_last;

    assign bus.w_valid = (fifo_count != '0);
    assign {bus.w_last, bus.w_data} = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_pairs != '0) ? ISSUE : FIN;
                end
            end
            ISSUE: begin
                if (issue && (pairs_left == CNT_W'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (burst_end) begin
                    state_next = FIN;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ISSUE) || (state == DRAIN);
        done = (state == FIN);
    end

    // Address issue and the tag pipe that marks when ROM data for an issued pair is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            next_addr         <= '0;
            pairs_left        <= '0;
            bus.addr_weight_1 <= '0;
            bus.addr_weight_2 <= '0;
            tag_valid         <= '0;
            tag_last          <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                next_addr  <= base_addr;
                pairs_left <= num_pairs;
            end
            if (issue) begin
                bus.addr_weight_1 <= next_addr;
                bus.addr_weight_2 <= next_addr + ADDR_W'(1);
                next_addr         <= next_addr + ADDR_W'(2);
                pairs_left        <= pairs_left - CNT_W'(1);
            end
            tag_valid[0] <= issue;
            tag_last[0]  <= issue && (pairs_left == CNT_W'(1));
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_last[i]  <= tag_last[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {tag_last[ROM_LAT-1], bus.dout_weight_2, bus.dout_weight_1};
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
                2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end
endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Self-checking bench for weight_fetch_ctrl: table-driven bursts, hand-written corner
// sequences and randomized backpressure against a queue-based reference model.
module tb_weight_fetch_ctrl;
    localparam int ADDR_W     = 17;
    localparam int DATA_W     = 8;
    localparam int ROM_LAT    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 16;

    typedef struct {
        logic [16:0] base;
        logic [15:0] n;
        logic [15:0] first_data;
        logic [15:0] last_data;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [16:0] base_addr;
    logic [15:0] num_pairs;
    logic        busy;
    logic        done;

    weight_fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wif ();

    weight_fetch_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT),
        .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_pairs(num_pairs), .busy(busy), .done(done), .bus(wif)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  salt = 8'h00;
    logic [16:0] expq[$];

    int          cyc = 0;
    int          accepted = 0;
    int          last_count = 0;
    int          done_count = 0;
    int          last_hs_cyc = -1;
    int          done_cyc = -1;
    logic [15:0] last_pair_data = '0;
    bit          hold_pending = 0;
    logic [16:0] held = '0;
    bit          track_issue = 0;
    logic [16:0] trk_base = '0;
    int          trk_n = 0;
    int          issued = 0;
    int          burst_acc = 0;
    logic [16:0] prev_addr1 = '0;
    logic [16:0] exp_addr;
    logic [16:0] exp_pair;

    function automatic logic [7:0] rom_val(input logic [16:0] a);
        return a[7:0] ^ salt;
    endfunction

    // ROM model: address registered in the DUT plus one ROM output register gives ROM_LAT=2
    always @(posedge clk) begin
        wif.dout_weight_1 <= rom_val(wif.addr_weight_1);
        wif.dout_weight_2 <= rom_val(wif.addr_weight_2);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: issue tracking, credit bound, hold stability and in-order scoreboard
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (track_issue && (wif.addr_weight_1 != prev_addr1)) begin
                exp_addr = trk_base + 17'(2 * issued);
                checkOutput("issue_addr_a", 32'(wif.addr_weight_1), 32'(exp_addr));
                checkOutput("issue_addr_b", 32'(wif.addr_weight_2), 32'(exp_addr + 17'd1));
                issued++;
                checkOutput("issue_count_bound", 32'(issued <= trk_n), 32'd1);
            end
            if (track_issue) begin
                checkOutput("credit_bound", 32'((issued - burst_acc) <= FIFO_DEPTH), 32'd1);
            end
            if (hold_pending) begin
                checkOutput("hold_valid", 32'(wif.w_valid), 32'd1);
                checkOutput("hold_data", 32'({wif.w_last, wif.w_data}), 32'(held));
            end
            if (wif.w_valid && wif.w_ready) begin
                accepted++;
                burst_acc++;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_pair: got 0x%0h, expected no pair", {wif.w_last, wif.w_data});
                end else begin
                    exp_pair = expq.pop_front();
                    checkOutput("pair_data", 32'({wif.w_last, wif.w_data}), 32'(exp_pair));
                end
                if (wif.w_last) begin
                    last_count++;
                    last_hs_cyc = cyc;
                    last_pair_data = wif.w_data;
                end
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
        end
        hold_pending = !rst && wif.w_valid && !wif.w_ready;
        held = {wif.w_last, wif.w_data};
        prev_addr1 = wif.addr_weight_1;
    end

    // Pulses start and loads the reference model with the pairs this burst must deliver
    task automatic applyStimulus(input logic [16:0] b, input logic [15:0] n);
        logic [16:0] a;
        @(negedge clk);
        for (int i = 0; i < int'(n); i++) begin
            a = b + 17'(2 * i);
            expq.push_back({(i == int'(n) - 1), rom_val(a + 17'd1), rom_val(a)});
        end
        trk_base = b;
        trk_n = int'(n);
        issued = 0;
        burst_acc = 0;
        track_issue = (n != 0) && (b != wif.addr_weight_1);
        base_addr = b;
        num_pairs = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput(name, 32'(done), 32'd1);
    endtask

    task automatic runBurst(input vec_t v);
        int          acc0, last0, done0, lat, k;
        logic [15:0] fdata;
        bit          got;
        acc0 = accepted;
        last0 = last_count;
        done0 = done_count;
        applyStimulus(v.base, v.n);
        lat = -1;
        got = 0;
        k = 0;
        fdata = '0;
        while (k < 400) begin
            if (wif.w_valid && lat < 0) begin
                lat = k;
                fdata = wif.w_data;
            end
            if (k == 0) checkOutput("busy_after_start", 32'(busy), 32'(v.n != 0));
            if (done) begin
                got = 1;
                break;
            end
            @(negedge clk);
            k++;
        end
        checkOutput("done_seen", 32'(got), 32'd1);
        checkOutput("first_valid_latency", 32'(lat), 32'(v.lat));
        if (v.n != 0) checkOutput("first_data", 32'(fdata), 32'(v.first_data));
        @(negedge clk);
        checkOutput("done_width", 32'(done), 32'd0);
        checkOutput("busy_after_done", 32'(busy), 32'd0);
        checkOutput("valid_after_done", 32'(wif.w_valid), 32'd0);
        checkOutput("pairs_delivered", 32'(accepted - acc0), 32'(v.n));
        checkOutput("last_count", 32'(last_count - last0), 32'(v.n != 0));
        checkOutput("done_count", 32'(done_count - done0), 32'd1);
        if (v.n != 0) begin
            checkOutput("last_data", 32'(last_pair_data), 32'(v.last_data));
            checkOutput("done_after_last", 32'(done_cyc), 32'(last_hs_cyc + 1));
        end
        if (track_issue) checkOutput("issued_pairs", 32'(issued), 32'(v.n));
        checkOutput("scoreboard_empty", 32'(expq.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs[5];
        vec_t        follow;
        int          acc0, done0, hs, k, n;
        logic [16:0] b;

        vecs[0] = '{17'h00010, 16'd4, 16'h1110, 16'h1716, 3};
        vecs[1] = '{17'h1FFFE, 16'd2, 16'hFFFE, 16'h0100, 3};
        vecs[2] = '{17'h00101, 16'd3, 16'h0201, 16'h0605, 3};
        vecs[3] = '{17'h000FF, 16'd1, 16'h00FF, 16'h00FF, 3};
        vecs[4] = '{17'h00040, 16'd0, 16'h0000, 16'h0000, -1};

        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        num_pairs = '0;
        wif.w_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_w_valid", 32'(wif.w_valid), 32'd0);
        checkOutput("reset_w_last", 32'(wif.w_last), 32'd0);
        checkOutput("reset_w_data", 32'(wif.w_data), 32'd0);
        checkOutput("reset_addr_a", 32'(wif.addr_weight_1), 32'd0);
        checkOutput("reset_addr_b", 32'(wif.addr_weight_2), 32'd0);
        rst = 1'b0;
        wif.w_ready = 1'b1;

        for (int i = 0; i < 5; i++) begin
            runBurst(vecs[i]);
        end

        // Backpressure: PE stalls for 10 cycles, only FIFO_DEPTH pairs may be outstanding
        wif.w_ready = 1'b0;
        acc0 = accepted;
        applyStimulus(17'h00200, 16'd8);
        repeat (10) @(negedge clk);
        checkOutput("stall_issued", 32'(issued), 32'(FIFO_DEPTH));
        checkOutput("stall_valid", 32'(wif.w_valid), 32'd1);
        checkOutput("stall_head", 32'(wif.w_data), 32'h0100);
        checkOutput("stall_no_accept", 32'(accepted - acc0), 32'd0);
        wif.w_ready = 1'b1;
        waitDone("stall_done_seen", 400);
        @(negedge clk);
        checkOutput("stall_pairs_delivered", 32'(accepted - acc0), 32'd8);
        checkOutput("stall_scoreboard_empty", 32'(expq.size()), 32'd0);

        // Ignored start while busy, then reset after pair 2 is accepted
        done0 = done_count;
        applyStimulus(17'h00300, 16'd6);
        base_addr = 17'h05000;
        num_pairs = 16'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hs = 0;
        k = 0;
        while (k < 100) begin
            if (wif.w_valid && wif.w_ready) hs++;
            if (hs == 3) break;
            @(negedge clk);
            k++;
        end
        checkOutput("mid_three_handshakes", 32'(hs), 32'd3);
        @(negedge clk);
        track_issue = 0;
        wif.w_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_reset_w_valid", 32'(wif.w_valid), 32'd0);
        checkOutput("mid_reset_busy", 32'(busy), 32'd0);
        checkOutput("mid_reset_done", 32'(done), 32'd0);
        rst = 1'b0;
        expq.delete();
        wif.w_ready = 1'b1;
        checkOutput("mid_reset_no_done", 32'(done_count - done0), 32'd0);
        follow = '{17'h00000, 16'd3, 16'h0100, 16'h0504, 3};
        runBurst(follow);

        // Random backpressure against the reference model with random ROM contents
        for (int r = 0; r < 3; r++) begin
            int last0;
            salt = 8'($urandom);
            n = (r == 0) ? 100 : int'($urandom_range(1, 40));
            b = 17'($urandom_range(0, 17'h1FFFF));
            if (b == wif.addr_weight_1) b = b + 17'd2;
            acc0 = accepted;
            last0 = last_count;
            done0 = done_count;
            applyStimulus(b, 16'(n));
            k = 0;
            while (!done && k < 3000) begin
                wif.w_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                k++;
            end
            checkOutput("rand_done_seen", 32'(done), 32'd1);
            wif.w_ready = 1'b1;
            @(negedge clk);
            checkOutput("rand_pairs_delivered", 32'(accepted - acc0), 32'(n));
            checkOutput("rand_last_count", 32'(last_count - last0), 32'd1);
            checkOutput("rand_done_count", 32'(done_count - done0), 32'd1);
            checkOutput("rand_issued", 32'(issued), 32'(n));
            checkOutput("rand_scoreboard_empty", 32'(expq.size()), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/weight_fetch_ctrl.md
Name: weight_fetch_ctrl

Overview:
Burst address generator and packer between weightROM and the PE. On a start pulse it streams a contiguous run of 8-bit weights from the dual-port weightROM: port A reads even offsets, port B reads odd offsets. It absorbs the fixed ROM read latency and delivers one packed 16-bit weight pair per cycle to the PE over a valid/ready handshake. A small credit-controlled FIFO absorbs PE backpressure without dropping or duplicating data.

Parameters:
ADDR_W, 17, weightROM address width.
DATA_W, 8, weight width per ROM port.
ROM_LAT, 2, clock edges from address presented to dout valid. Must be >= 1.
FIFO_DEPTH, 4, output FIFO entries. Must be a power of 2 and >= ROM_LAT+2 for full throughput.
CNT_W, 16, width of num_pairs.

Ports:
clk  in  1  system clock (clk_wiz output)
rst  in  1  synchronous active-high reset
start  in  1  single-cycle burst request; sampled only when busy=0
base_addr  in  ADDR_W  first weight address (even or odd allowed)
num_pairs  in  CNT_W  number of weight pairs to fetch
busy  out  1  burst in progress
done  out  1  one-cycle completion pulse
addr_weight_1  out  ADDR_W  ROM port A address (registered)
addr_weight_2  out  ADDR_W  ROM port B address (registered)
dout_weight_1  in  DATA_W  ROM port A data
dout_weight_2  in  DATA_W  ROM port B data
w_valid  out  1  pair available to PE
w_ready  in  1  PE accepts pair
w_data  out  2*DATA_W  {port B weight, port A weight}
w_last  out  1  marks final pair of the burst; qualified by w_valid

Behaviour:
- Reset: every output is 0 (busy, done, w_valid, w_last, w_data, both addresses). FSM goes to IDLE. In-flight tag pipe is cleared, FIFO pointers/count are zeroed and FIFO storage is cleared. rst has priority over all other events, including mid-burst; the partial burst is discarded with no done pulse.
- FSM has four states: IDLE, ISSUE, DRAIN, FIN.
  - IDLE: on start with num_pairs!=0, latch base_addr and num_pairs, then go to ISSUE with busy=1. On start with num_pairs==0, go to FIN.
  - ISSUE -> DRAIN when the final pair's address is issued.
  - DRAIN -> FIN on the handshake w_valid&w_ready&w_last.
  - FIN: done=1 for exactly one cycle, busy=0, then IDLE.
- start while busy=1 is ignored.
- Issue rule, evaluated in ISSUE each cycle: issue when inflight + fifo_count < FIFO_DEPTH. A same-cycle pop is not credited. On issue for pair i: addr_weight_1 = base+2i, addr_weight_2 = base+2i+1.
- Address arithmetic is modulo 2^ADDR_W, so addresses wrap from 0x1FFFF to 0x00000.
- Address outputs hold their last value when not issuing.
- In-flight tracking: a ROM_LAT-deep shift register carries {valid, last} alongside each issued address. When a valid tag exits the register, {dout_weight_2, dout_weight_1} and last are pushed into the FIFO. The credit rule guarantees the FIFO never overflows; the bench asserts this.
- Output: w_valid = FIFO not empty. w_data and w_last reflect the FIFO head. A pop occurs on w_valid&w_ready. Push and pop in the same cycle leave the count unchanged.
- Latency: start is sampled at edge E0. Pair 0 addresses are visible after E1. w_valid is first high after edge E(1+ROM_LAT), i.e. after E3 at the default ROM_LAT=2.
- Throughput: 1 pair/clk while w_ready=1.
- done rises after the edge on which the last handshake occurs, plus one FIN cycle. busy falls with done.
- w_valid, once high, stays high with stable w_data until accepted.

Test Plan:
1. Preload ROM[a]=a[7:0]. base=0x00010, num_pairs=4, w_ready=1 -> addresses (0x10,0x11),(0x12,0x13),(0x14,0x15),(0x16,0x17); w_data=0x1110,0x1312,0x1514,0x1716 on consecutive cycles; w_valid first high 3 cycles after start; w_last only on 0x1716; done one cycle after it.
2. Backpressure: num_pairs=8, w_ready=0 for 10 cycles then 1 -> at most FIFO_DEPTH addresses issued while stalled; no overflow; w_data held stable; all 8 pairs delivered in order with no duplicates.
3. Wrap: base=0x1FFFE, num_pairs=2 -> addresses (0x1FFFE,0x1FFFF) then (0x00000,0x00001).
4. num_pairs=0 -> done pulse exactly one cycle; w_valid never asserts; busy stays 0.
5. Mid-burst reset and ignored start:
   - start pulsed again during a burst -> ignored.
   - rst asserted after pair 2 is accepted -> next cycle w_valid=0, busy=0, done=0.
   - A following burst (base=0, num_pairs=3) completes with correct data and no stale pairs.
6. Random w_ready (50%), num_pairs=100, random base -> scoreboard matches ROM contents in order; exactly one w_last and one done.
